// File: rtl/echo_ctrl.sv
// echo_ctrl: per-sample sequencer for the stereo echo engine (accept, start, wait, output).
// Define ECHO_GLIDE_EN to step delay_samples by one per accepted sample instead of jumping.
module echo_ctrl #(
    parameter int SAMPLE_WIDTH     = 13,
    parameter int SINGLE_ADC_WIDTH = 16,
    parameter int SINGLE_DAC_WIDTH = 19,
    parameter int ADC_DATA_WIDTH   = 32,
    parameter int DAC_DATA_WIDTH   = 38,
    parameter int MAX_DELAY        = 8191,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sample_valid,
    input  logic [ADC_DATA_WIDTH-1:0] sample_in,
    input  logic [SAMPLE_WIDTH-1:0]   delay_target,
    input  logic                      bypass,
    output logic                      echo_start,
    output logic [ADC_DATA_WIDTH-1:0] echo_din,
    output logic [SAMPLE_WIDTH-1:0]   delay_samples,
    input  logic                      echo_Done,
    input  logic [DAC_DATA_WIDTH-1:0] Echo_Out,
    output logic [DAC_DATA_WIDTH-1:0] dout,
    output logic                      dout_valid,
    output logic                      busy,
    output logic                      overrun,
    output logic                      timeout_err
);

    localparam int EXT = SINGLE_DAC_WIDTH - SINGLE_ADC_WIDTH;
    localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SAMPLE_WIDTH-1:0] MAX_D = SAMPLE_WIDTH'(MAX_DELAY);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        OUT
    } state_t;

    state_t                    state_q, state_d;
    logic [ADC_DATA_WIDTH-1:0] din_q, din_d;
    logic [SAMPLE_WIDTH-1:0]   dly_q, dly_d;
    logic [DAC_DATA_WIDTH-1:0] dout_q, dout_d;
    logic [TW-1:0]             wd_q, wd_d;
    logic [SAMPLE_WIDTH-1:0]   tgt_clamped;
    logic [SAMPLE_WIDTH-1:0]   dly_next;
    logic                      to_fire;

    // Sign-extend each channel of a {left, right} sample to DAC width.
    function automatic logic [DAC_DATA_WIDTH-1:0] sext(
        input logic [ADC_DATA_WIDTH-1:0] s
    );
        logic [SINGLE_ADC_WIDTH-1:0] l;
        logic [SINGLE_ADC_WIDTH-1:0] r;
        l = s[ADC_DATA_WIDTH-1:SINGLE_ADC_WIDTH];
        r = s[SINGLE_ADC_WIDTH-1:0];
        return {{EXT{l[SINGLE_ADC_WIDTH-1]}}, l,
                {EXT{r[SINGLE_ADC_WIDTH-1]}}, r};
    endfunction

    always_comb begin
        tgt_clamped = delay_target;
        if (delay_target > MAX_D) begin
            tgt_clamped = MAX_D;
        end
    end

`ifdef ECHO_GLIDE_EN
    always_comb begin
        dly_next = dly_q;
        if (dly_q < tgt_clamped) begin
            dly_next = dly_q + SAMPLE_WIDTH'(1);
        end else if (dly_q > tgt_clamped) begin
            dly_next = dly_q - SAMPLE_WIDTH'(1);
        end
    end
`else
    always_comb begin
        dly_next = tgt_clamped;
    end
`endif

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        dly_d   = dly_q;
        dout_d  = dout_q;
        wd_d    = wd_q;
        to_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    din_d = sample_in;
                    dly_d = dly_next;
                    if (bypass) begin
                        dout_d  = sext(sample_in);
                        state_d = OUT;
                    end else begin
                        state_d = START;
                    end
                end
            end
            START: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Done wins over a watchdog expiry landing in the same cycle.
                if (echo_Done) begin
                    dout_d  = Echo_Out;
                    state_d = OUT;
                end else if (wd_q == WD_LAST) begin
                    dout_d  = sext(din_q);
                    to_fire = 1'b1;
                    state_d = OUT;
                end else begin
                    wd_d = wd_q + TW'(1);
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            din_q   <= '0;
            dly_q   <= '0;
            dout_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            dly_q   <= dly_d;
            dout_q  <= dout_d;
            wd_q    <= wd_d;
        end
    end

    assign echo_start    = (state_q == START);
    assign dout_valid    = (state_q == OUT);
    assign busy          = (state_q != IDLE);
    assign overrun       = sample_valid && (state_q != IDLE);
    assign timeout_err   = to_fire;
    assign echo_din      = din_q;
    assign delay_samples = dly_q;
    assign dout          = dout_q;

endmodule
